// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte-stream requesters share one UART transmitter.
// An owner keeps the transmitter for a whole packet, with a hold timeout if it stalls.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned HOLD_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   ack,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               grant_valid,
  output logic [1:0]         grant_id,
  output logic               timeout_evt
);

  localparam int unsigned CntW     = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [1:0]  LastInit = 2'(N_REQ - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;

  logic [2:0]      stateQ, stateD;
  logic [1:0]      ownerQ, ownerD;
  logic [1:0]      lastOwnerQ, lastOwnerD;
  logic            lastQ, lastD;
  logic [CntW-1:0] cntQ, cntD;

  logic            ownerReq, ownerLast, timeout;
  logic [7:0]      ownerData;
  logic            hiFound;
  logic [1:0]      hiPick, loPick, pick;

  // Lowest requester above lastOwner wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    hiFound = 1'b0;
    hiPick  = '0;
    loPick  = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        loPick = 2'(i);
        if (i > int'(lastOwnerQ)) begin
          hiFound = 1'b1;
          hiPick  = 2'(i);
        end
      end
    end
    pick = hiFound ? hiPick : loPick;
  end

  always_comb begin
    ownerReq  = 1'b0;
    ownerLast = 1'b0;
    ownerData = 8'h00;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (ownerQ == 2'(i)) begin
        ownerReq  = req[i];
        ownerLast = req_last[i];
        ownerData = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    stateD     = stateQ;
    ownerD     = ownerQ;
    lastOwnerD = lastOwnerQ;
    lastD      = lastQ;
    cntD       = '0;
    timeout    = 1'b0;
    case (stateQ)
      IDLE: begin
        if (|req) begin
          ownerD = pick;
          stateD = START;
        end
      end
      START: begin
        lastD  = ownerLast;
        stateD = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) stateD = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (lastQ) begin
            stateD     = IDLE;
            lastOwnerD = ownerQ;
          end else if (ownerReq) begin
            stateD = START;
          end else begin
            stateD = HOLD;
          end
        end
      end
      HOLD: begin
        // A returning owner takes precedence over a timeout in the same cycle.
        if (ownerReq) begin
          stateD = START;
        end else if (cntQ == CntW'(HOLD_TIMEOUT)) begin
          timeout    = 1'b1;
          stateD     = IDLE;
          lastOwnerD = ownerQ;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ     <= IDLE;
      ownerQ     <= '0;
      lastOwnerQ <= LastInit;
      lastQ      <= 1'b0;
      cntQ       <= '0;
    end else begin
      stateQ     <= stateD;
      ownerQ     <= ownerD;
      lastOwnerQ <= lastOwnerD;
      lastQ      <= lastD;
      cntQ       <= cntD;
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      ack[i] = (stateQ == START) && (ownerQ == 2'(i));
    end
  end

  assign tx_start    = (stateQ == START);
  assign tx_data     = tx_start ? ownerData : 8'h00;
  assign grant_valid = (stateQ != IDLE);
  assign grant_id    = ownerQ;
  assign timeout_evt = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a simple UART busy model and a tx scoreboard.
module tb_uart_tx_arbiter;

  localparam int unsigned NReq    = 3;
  localparam int unsigned HoldTo  = 15;
  localparam int unsigned BusyLen = 3;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        timeout_evt;

  logic stuckBusy = 1'b0;
  logic autoBusy  = 1'b1;
  int   busyCnt;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  int   timeoutCnt = 0;
  int   timeoutCycle = -1;
  int   ackCnt[3] = '{0, 0, 0};
  int   c;

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [8:0] src2[$];
  exp_t       expQ[$];
  int         txCycles[$];

  uart_tx_arbiter #(
    .N_REQ       (NReq),
    .HOLD_TIMEOUT(HoldTo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .ack        (ack),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // UART model: busy for BusyLen cycles starting the cycle after tx_start.
  always @(posedge clk or negedge rst) begin
    if (!rst) busyCnt <= 0;
    else if (autoBusy && tx_start) busyCnt <= BusyLen;
    else if (busyCnt != 0) busyCnt <= busyCnt - 1;
  end
  assign tx_busy = stuckBusy | (busyCnt != 0);

  function automatic void refresh();
    req      = '0;
    req_data = '0;
    req_last = '0;
    if (src0.size() > 0) begin
      req[0] = 1'b1; req_data[7:0] = src0[0][7:0]; req_last[0] = src0[0][8];
    end
    if (src1.size() > 0) begin
      req[1] = 1'b1; req_data[15:8] = src1[0][7:0]; req_last[1] = src1[0][8];
    end
    if (src2.size() > 0) begin
      req[2] = 1'b1; req_data[23:16] = src2[0][7:0]; req_last[2] = src2[0][8];
    end
  endfunction

  function automatic void enq(input int id, input logic [7:0] d, input logic l);
    case (id)
      0:       src0.push_back({l, d});
      1:       src1.push_back({l, d});
      default: src2.push_back({l, d});
    endcase
    refresh();
  endfunction

  function automatic void pushExp(input logic [1:0] id, input logic [7:0] d);
    expQ.push_back('{id: id, data: d});
  endfunction

  function automatic int txAt(input int k);
    return (txCycles.size() > k) ? txCycles[k] : -1;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req_v);
    end
  endfunction

  // Requester side: a byte is consumed on the edge that ends its ack cycle.
  initial begin
    logic [2:0] a;
    forever begin
      @(negedge clk);
      a = ack;
      @(posedge clk);
      #1;
      if (a[0] && src0.size() > 0) void'(src0.pop_front());
      if (a[1] && src1.size() > 0) void'(src1.pop_front());
      if (a[2] && src2.size() > 0) void'(src2.pop_front());
      refresh();
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 3; i++) if (ack[i]) ackCnt[i]++;
        if (timeout_evt) begin
          timeoutCnt++;
          timeoutCycle = cycle;
        end
        if (tx_start) begin
          txCycles.push_back(cycle);
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx: data %0h from id %0d, expected no transfer",
                     tx_data, grant_id);
          end else begin
            e = expQ.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e.data));
            chk("tx_grant_id", 32'(grant_id), 32'(e.id));
            chk("tx_ack", 32'(ack), 32'(3'b001 << e.id));
            chk("tx_grant_valid", 32'(grant_valid), 32'd1);
          end
        end else if (ack !== 3'b000) begin
          checks++;
          errors++;
          $display("FAIL ack_outside_start: ack %b, expected 000", ack);
        end
      end
    end
  end

  task automatic chkResetOuts(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_timeout_evt"}, 32'(timeout_evt), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    src0.delete(); src1.delete(); src2.delete();
    expQ.delete();
    refresh();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    txCycles.delete();
    timeoutCnt   = 0;
    timeoutCycle = -1;
    for (int i = 0; i < 3; i++) ackCnt[i] = 0;
  endtask

  task automatic waitIdle(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (expQ.size() == 0 && grant_valid === 1'b0 && tx_busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_complete: %0d transfers outstanding, grant_valid %b, expected done in 300",
               name, expQ.size(), grant_valid);
    end
  endtask

  initial begin
    refresh();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chkResetOuts("reset");
    rst = 1'b1;

    // Single requester, one-cycle grant latency.
    @(negedge clk);
    c = cycle;
    enq(0, 8'h41, 1'b1);
    pushExp(2'd0, 8'h41);
    waitIdle("single");
    chk("single_latency", 32'(txAt(0)), 32'(c + 1));
    chk("single_idle", 32'(grant_valid), 32'd0);

    // Round-robin with all three requesters pending.
    doReset();
    @(negedge clk);
    enq(0, 8'hA0, 1'b1); enq(0, 8'hA3, 1'b1);
    enq(1, 8'hA1, 1'b1); enq(1, 8'hA4, 1'b1);
    enq(2, 8'hA2, 1'b1); enq(2, 8'hA5, 1'b1);
    pushExp(2'd0, 8'hA0); pushExp(2'd1, 8'hA1); pushExp(2'd2, 8'hA2);
    pushExp(2'd0, 8'hA3); pushExp(2'd1, 8'hA4); pushExp(2'd2, 8'hA5);
    waitIdle("rr");
    chk("rr_ack0", 32'(ackCnt[0]), 32'd2);
    chk("rr_ack1", 32'(ackCnt[1]), 32'd2);
    chk("rr_ack2", 32'(ackCnt[2]), 32'd2);

    // Packet lock: req1 waits for all of req0's packet.
    doReset();
    @(negedge clk);
    enq(0, 8'h10, 1'b0); enq(0, 8'h11, 1'b0); enq(0, 8'h12, 1'b1);
    enq(1, 8'h20, 1'b1);
    pushExp(2'd0, 8'h10); pushExp(2'd0, 8'h11); pushExp(2'd0, 8'h12); pushExp(2'd1, 8'h20);
    waitIdle("lock");
    chk("lock_ack0", 32'(ackCnt[0]), 32'd3);

    // Hold timeout: HOLD entered BusyLen+2 cycles after tx_start, timeout HoldTo cycles later.
    doReset();
    @(negedge clk);
    enq(0, 8'h30, 1'b0);
    enq(2, 8'h32, 1'b1);
    pushExp(2'd0, 8'h30); pushExp(2'd2, 8'h32);
    waitIdle("hold");
    chk("hold_timeout_pulses", 32'(timeoutCnt), 32'd1);
    chk("hold_timeout_cycle", 32'(timeoutCycle), 32'(txAt(0) + int'(BusyLen) + 2 + int'(HoldTo)));
    chk("hold_next_grant_cycle", 32'(txAt(1)), 32'(timeoutCycle + 2));

    // Reset during WAIT_DONE, then requester 1 wins first.
    doReset();
    @(negedge clk);
    c = cycle;
    enq(0, 8'h50, 1'b1);
    pushExp(2'd0, 8'h50);
    repeat (3) @(negedge clk);
    chk("midframe_granted", 32'(grant_valid), 32'd1);
    rst = 1'b0;
    #1;
    chkResetOuts("midframe");
    src0.delete();
    refresh();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    enq(1, 8'h61, 1'b1);
    pushExp(2'd1, 8'h61);
    waitIdle("midframe");
    chk("midframe_ack0", 32'(ackCnt[0]), 32'd1);
    chk("midframe_ack1", 32'(ackCnt[1]), 32'd1);

    // Busy already high at START: WAIT_BUSY passes straight through.
    doReset();
    autoBusy  = 1'b0;
    stuckBusy = 1'b1;
    @(negedge clk);
    c = cycle;
    enq(0, 8'h70, 1'b0); enq(0, 8'h71, 1'b1);
    pushExp(2'd0, 8'h70); pushExp(2'd0, 8'h71);
    repeat (3) @(negedge clk);
    stuckBusy = 1'b0;
    autoBusy  = 1'b1;
    waitIdle("early_busy");
    chk("early_first_tx", 32'(txAt(0)), 32'(c + 1));
    chk("early_second_tx", 32'(txAt(1)), 32'(c + 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, giving the number of byte-stream requesters (2..4).
REQ-002 The block SHALL have parameter HOLD_TIMEOUT, default 1023, giving the idle cycles tolerated mid-packet before forced release.
REQ-003 Port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 Port req, input, N_REQ bits: requester i has a byte pending.
REQ-006 Port req_data, input, 8*N_REQ bits: byte of requester i, located at bits [8i+7:8i].
REQ-007 Port req_last, input, N_REQ bits: the pending byte of requester i ends its packet.
REQ-008 Port ack, output, N_REQ bits: one-cycle pulse meaning the byte of requester i was consumed.
REQ-009 Port tx_start, output, 1 bit: one-cycle start strobe to the UART transmitter.
REQ-010 Port tx_data, output, 8 bits: byte to the UART transmitter, valid while tx_start=1.
REQ-011 Port tx_busy, input, 1 bit: the UART transmitter is shifting a frame.
REQ-012 Port grant_valid, output, 1 bit: a requester currently owns the transmitter.
REQ-013 Port grant_id, output, 2 bits: index of the owning requester, meaningful only while grant_valid=1.
REQ-014 Port timeout_evt, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-016 In IDLE with req≠0, the block SHALL grant by round-robin, searching from (last_owner+1) mod N_REQ upward, and enter START on the next edge.
REQ-017 In START, tx_start=1, tx_data=the owner's req_data, and ack[owner]=1 for exactly one cycle; the block SHALL latch req_last[owner] and enter WAIT_BUSY.
REQ-018 In WAIT_BUSY, the block SHALL stay until tx_busy=1, then enter WAIT_DONE.
REQ-019 In WAIT_DONE, the block SHALL stay until tx_busy=0, then act as follows:
- latched last=1: go to IDLE, release grant, last_owner := owner.
- latched last=0 and req[owner]=1: go to START.
- otherwise: go to HOLD.
REQ-020 In HOLD, req[owner]=1 SHALL move to START, and other requesters SHALL NOT be granted (packet lock).
REQ-021 In HOLD, a counter SHALL increment each cycle; when it reaches HOLD_TIMEOUT, the block SHALL pulse timeout_evt, release to IDLE and set last_owner := owner; the counter clears on leaving HOLD.
REQ-022 grant_valid SHALL be 1 in START, WAIT_BUSY, WAIT_DONE and HOLD, and 0 in IDLE.
REQ-023 Throughput: minimum latency from IDLE with req asserted to tx_start SHALL be 1 cycle; back-to-back bytes of one packet are limited only by tx_busy.
REQ-024 A change of req on a non-owner while granted SHALL have no effect until release.
REQ-025 ack SHALL be one-hot or zero, and SHALL never be asserted outside START.
REQ-026 If req[owner] drops during WAIT_BUSY or WAIT_DONE, the byte already started SHALL complete normally.
REQ-027 If tx_busy is already 1 on entry to WAIT_BUSY, the block SHALL pass to WAIT_DONE on the next edge.

Reset
REQ-028 On rst=0, the block SHALL enter IDLE immediately (asynchronously) with:
- ack=0, tx_start=0, tx_data=8'h00, grant_valid=0, grant_id=0, timeout_evt=0;
- hold counter=0, latched last=0;
- last_owner=N_REQ-1, so that requester 0 wins first.
REQ-029 Reset asserted mid-frame SHALL abort the packet with no further ack; after rst returns to 1, the first grant SHALL follow REQ-016.

Verification
REQ-030 Single-requester grant: after reset, req=3'b001, data 8'h41, last=1 -> tx_start one cycle later with tx_data=8'h41, ack=3'b001 in the same cycle; after the tx_busy 1->0 sequence, the block returns to IDLE.
REQ-031 Round-robin: after reset, req=3'b111 held with last=1 -> grant order 0,1,2,0; each owner gets exactly one ack per byte.
REQ-032 Packet lock: req0 sends 3 bytes (8'h10, 8'h11, 8'h12; last on the third) while req1 is asserted throughout -> all three bytes of req0 go out before req1's first tx_start.
REQ-033 Hold timeout: req0 sends a byte with last=0, then drops req; HOLD_TIMEOUT=15 -> timeout_evt pulses 15 cycles after HOLD entry, and the pending req2 is granted next.
REQ-034 Reset mid-frame: rst=0 during WAIT_DONE -> all outputs at reset values at once; after release with req=3'b010 -> grant_id=1.
REQ-035 Early busy: tx_busy stuck at 1 at START -> WAIT_BUSY exits in 1 cycle; no second tx_start while tx_busy=1.
